// File: rtl/enable_led_sequencer_pkg.sv
// Shared mode encoding, state type and helpers for the enable LED sequencer.
// Optional feature macro: ENABLE_LED_SEQUENCER_LONG_PRESS_EN (see enable_led_sequencer.sv).
package enable_led_sequencer_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;

    typedef enum logic [1:0] {
        StOff     = MODE_OFF,
        StOn      = MODE_ON,
        StBlink   = MODE_BLINK,
        StIllegal = 2'd3
    } mode_e;

    // Width of a counter whose largest value is terminal.
    function automatic int unsigned cnt_width(input int unsigned terminal);
        return $clog2(terminal) + 1;
    endfunction

    function automatic mode_e next_mode(input mode_e cur, input logic ev);
        case (cur)
            StOff:   return ev ? StOn : StOff;
            StOn:    return ev ? StBlink : StOn;
            StBlink: return ev ? StOff : StBlink;
            default: return StOff;
        endcase
    endfunction

    function automatic logic mode_led(input mode_e m, input logic phase);
        case (m)
            StOn:    return 1'b1;
            StBlink: return phase;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/enable_led_sequencer_debounce_filter.sv
// Two-flop synchronizer plus counter-based debounce for one raw button.
// Emits registered single-cycle pulses on accepted rising and falling level changes.
module debounce_filter
    import enable_led_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 125000
) (
    input  logic ext_clk,
    input  logic ext_rst_n,
    input  logic raw,
    output logic stable,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    always_ff @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            cnt        <= '0;
            stable     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync_q1    <= raw;
            sync_q2    <= sync_q1;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (sync_q2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Difference held for DEBOUNCE_CYCLES samples: accept it.
                stable     <= sync_q2;
                cnt        <= '0;
                rise_pulse <= sync_q2;
                fall_pulse <= ~sync_q2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/enable_led_sequencer.sv
// Per-channel OFF/ON/BLINK sequencer driving the registered enable_led vector.
// Define ENABLE_LED_SEQUENCER_LONG_PRESS_EN for release-triggered events with long-press clear-all.
module enable_led_sequencer
    import enable_led_sequencer_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS      = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 125000,
    parameter int unsigned BLINK_HALF_PERIOD = 62500000,
    parameter int unsigned LONG_PRESS_CYCLES = 250000000
) (
    input  logic                      ext_clk,
    input  logic                      ext_rst_n,
    input  logic [NUM_CHANNELS-1:0]   button_raw,
    output logic [NUM_CHANNELS-1:0]   enable_led,
    output logic [2*NUM_CHANNELS-1:0] mode
);

    localparam int unsigned BW = cnt_width(BLINK_HALF_PERIOD - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF_PERIOD - 1);

    logic [NUM_CHANNELS-1:0] stable;
    logic [NUM_CHANNELS-1:0] rise;
    logic [NUM_CHANNELS-1:0] fall;
    logic [NUM_CHANNELS-1:0] btn_event;
    logic                    clear_all;

    mode_e                   state_q [NUM_CHANNELS];
    mode_e                   state_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] led_d;
    logic [BW-1:0]           blink_cnt_q;
    logic [BW-1:0]           blink_cnt_d;
    logic                    blink_phase_q;
    logic                    blink_phase_d;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_db
        debounce_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_filter (
            .ext_clk   (ext_clk),
            .ext_rst_n (ext_rst_n),
            .raw       (button_raw[i]),
            .stable    (stable[i]),
            .rise_pulse(rise[i]),
            .fall_pulse(fall[i])
        );
    end

`ifdef ENABLE_LED_SEQUENCER_LONG_PRESS_EN
    localparam int unsigned HW = cnt_width(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES - 1);

    logic [HW-1:0]           hold_cnt_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] long_seen_q;
    logic [NUM_CHANNELS-1:0] long_hit;
    logic                    unused_sig;

    assign unused_sig = ^rise;

    always_comb begin
        long_hit = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            long_hit[i] = stable[i] && (hold_cnt_q[i] == HOLD_MAX) && !long_seen_q[i];
        end
    end

    // A release that ends a long hold is swallowed.
    assign btn_event = fall & ~long_seen_q;
    assign clear_all = |long_hit;

    always_ff @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                hold_cnt_q[i] <= '0;
            end
            long_seen_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (!stable[i]) begin
                    hold_cnt_q[i]  <= '0;
                    long_seen_q[i] <= 1'b0;
                end else begin
                    if (hold_cnt_q[i] != HOLD_MAX) begin
                        hold_cnt_q[i] <= hold_cnt_q[i] + 1'b1;
                    end
                    if (long_hit[i]) begin
                        long_seen_q[i] <= 1'b1;
                    end
                end
            end
        end
    end
`else
    logic unused_sig;

    assign unused_sig = ^{stable, fall, 32'(LONG_PRESS_CYCLES)};
    assign btn_event  = rise;
    assign clear_all  = 1'b0;
`endif

    always_comb begin
        blink_cnt_d   = (blink_cnt_q == BLINK_MAX) ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ (blink_cnt_q == BLINK_MAX);
        led_d         = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            state_d[i] = clear_all ? StOff : next_mode(state_q[i], btn_event[i]);
            // Decode from next-cycle state and phase so the output lines up with mode.
            led_d[i]   = mode_led(state_d[i], blink_phase_d);
        end
    end

    always_ff @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i] <= StOff;
            end
            enable_led    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i] <= state_d[i];
            end
            enable_led    <= led_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    always_comb begin
        mode = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            mode[2*i +: 2] = state_q[i];
        end
    end

endmodule

// File: tb/tb_enable_led_sequencer.sv
// Directed and randomized bench for enable_led_sequencer against a sample-window reference model.
// Build with ENABLE_LED_SEQUENCER_LONG_PRESS_EN to exercise the long-press variant.
module tb_enable_led_sequencer;

    localparam int D  = 4;
    localparam int H  = 3;
    localparam int LP = 10;

    logic       ext_clk = 1'b0;
    logic       ext_rst_n = 1'b0;
    logic [1:0] button_raw = 2'b00;
    logic [1:0] enable_led;
    logic [3:0] mode;

    int vectors = 0;
    int errs    = 0;

    // Reference model state: raw sample history per edge, accepted levels, modes.
    logic hist [2][4096];
    logic [1:0] stab;
    logic [1:0] pend;
    logic       clr_pend;
    int         rise_e [2];
    int         mdl [2];
    int         k;

    enable_led_sequencer #(
        .NUM_CHANNELS     (2),
        .DEBOUNCE_CYCLES  (D),
        .BLINK_HALF_PERIOD(H),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .ext_clk   (ext_clk),
        .ext_rst_n (ext_rst_n),
        .button_raw(button_raw),
        .enable_led(enable_led),
        .mode      (mode)
    );

    always #5 ext_clk = ~ext_clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, k);
        end
    endtask

    function automatic logic samp(input int ch, input int idx);
        if (idx < 1) return 1'b0;
        return hist[ch][idx];
    endfunction

    task automatic model_reset();
        k        = 0;
        stab     = '0;
        pend     = '0;
        clr_pend = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            mdl[ch]    = 0;
            rise_e[ch] = 0;
            for (int i = 0; i < 4096; i++) hist[ch][i] = 1'b0;
        end
    endtask

    // Level accepted at edge k when the raw samples of edges k-D-1..k-2 all differ from it.
    task automatic model_edge(input logic [1:0] r);
        logic flip;
        k++;
        if (clr_pend) begin
            mdl[0] = 0;
            mdl[1] = 0;
        end else begin
            for (int ch = 0; ch < 2; ch++) if (pend[ch]) mdl[ch] = (mdl[ch] + 1) % 3;
        end
        clr_pend = 1'b0;
        pend     = '0;
        for (int ch = 0; ch < 2; ch++) begin
            hist[ch][k] = r[ch];
            flip = 1'b1;
            for (int j = k - D - 1; j <= k - 2; j++) if (samp(ch, j) == stab[ch]) flip = 1'b0;
            if (flip) begin
                stab[ch] = ~stab[ch];
`ifdef ENABLE_LED_SEQUENCER_LONG_PRESS_EN
                if (stab[ch]) rise_e[ch] = k;
                else pend[ch] = ((k - rise_e[ch]) < LP);
`else
                pend[ch] = stab[ch];
`endif
            end
`ifdef ENABLE_LED_SEQUENCER_LONG_PRESS_EN
            if (stab[ch] && (k - rise_e[ch] == LP - 1)) clr_pend = 1'b1;
`endif
        end
    endtask

    task automatic check_model();
        logic [3:0] em;
        logic [1:0] el;
        for (int ch = 0; ch < 2; ch++) begin
            em[2*ch +: 2] = 2'(mdl[ch]);
            el[ch] = (mdl[ch] == 1) || (mdl[ch] == 2 && ((k / H) % 2) == 1);
        end
        chk("mode", 8'(mode), 8'(em));
        chk("enable_led", 8'(enable_led), 8'(el));
    endtask

    task automatic step(input logic [1:0] r);
        button_raw = r;
        @(posedge ext_clk);
        model_edge(r);
        @(negedge ext_clk);
        check_model();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge ext_clk);
        chk("reset_mode", 8'(mode), 8'h00);
        chk("reset_led", 8'(enable_led), 8'h00);
        ext_rst_n = 1'b1;

        // Ch0 raw high first sampled at edge 10.
        repeat (9) step(2'b00);
        repeat (6) step(2'b01);
        chk("pre_latency_mode", 8'(mode), 8'h00);
`ifndef ENABLE_LED_SEQUENCER_LONG_PRESS_EN
        step(2'b01);
        chk("latency_mode", 8'(mode), 8'h01);
        chk("latency_led", 8'(enable_led), 8'h01);
`endif
        repeat (10) step(2'b00);

        // Short glitch on ch1 must not register.
        repeat (3) step(2'b10);
        repeat (10) step(2'b00);
        chk("glitch_mode", 8'(mode), 8'h01);

        // Second press -> BLINK, observe several blink phases.
        repeat (5) step(2'b01);
        repeat (14) step(2'b00);
        chk("blink_mode", 8'(mode), 8'h02);
        repeat (5) step(2'b01);
        repeat (10) step(2'b00);
        chk("off_mode", 8'(mode), 8'h00);

        // Both channels on the same edge.
        repeat (5) step(2'b11);
        repeat (10) step(2'b00);
        chk("both_mode", 8'(mode), 8'h05);

`ifdef ENABLE_LED_SEQUENCER_LONG_PRESS_EN
        repeat (20) step(2'b01);
        repeat (10) step(2'b00);
        chk("long_press_mode", 8'(mode), 8'h00);
        repeat (6) step(2'b01);
        repeat (10) step(2'b00);
        chk("short_press_mode", 8'(mode), 8'h01);
`endif

        // Randomized level runs, including sub-debounce glitches.
        for (int s = 0; s < 60; s++) begin
            logic [1:0] r;
            int len;
            r   = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 8);
            repeat (len) step(r);
        end
        repeat (12) step(2'b00);

        // Reset asserted mid-cycle while ch0 is held.
        repeat (4) step(2'b01);
        #2 ext_rst_n = 1'b0;
        #1;
        chk("async_rst_mode", 8'(mode), 8'h00);
        chk("async_rst_led", 8'(enable_led), 8'h00);
        @(negedge ext_clk);
        ext_rst_n = 1'b1;
        model_reset();
        repeat (8) step(2'b01);
        repeat (10) step(2'b00);
        chk("post_rst_press_mode", 8'(mode), 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
